// File: rtl/ex_hazard_pkg.sv
// rtl/ex_hazard_pkg.sv - shared constants and stage-entry type for the EX hazard/forwarding unit
package ex_hazard_pkg;

  localparam int REG_AW_DEF  = 5;
  localparam int MAX_DEPTH   = 8;
  localparam int MAX_NUM_SRC = 4;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } stage_t;

endpackage

// File: rtl/ex_hazard_fwd_unit_if.sv
// rtl/ex_hazard_fwd_unit_if.sv - ID/EX hazard bus; o_err present only with EX_HAZARD_FWD_CHECK_EN
interface ex_hazard_fwd_unit_if #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int REG_AW  = 5
);
  localparam int SEL_W = $clog2(DEPTH);

  logic                      i_id_valid;
  logic [NUM_SRC*REG_AW-1:0] i_id_rs;
  logic [REG_AW-1:0]         i_id_rd;
  logic                      i_id_regwrite;
  logic                      i_id_memread;
  logic                      i_hold;
  logic                      i_flush;
  logic                      o_stall;
  logic [NUM_SRC*SEL_W-1:0]  o_fwd_sel;
  logic                      o_ex_valid;
`ifdef EX_HAZARD_FWD_CHECK_EN
  logic                      o_err;
`endif

  modport master (
    output i_id_valid, i_id_rs, i_id_rd, i_id_regwrite, i_id_memread, i_hold, i_flush,
`ifdef EX_HAZARD_FWD_CHECK_EN
    input  o_err,
`endif
    input  o_stall, o_fwd_sel, o_ex_valid
  );

  modport slave (
    input  i_id_valid, i_id_rs, i_id_rd, i_id_regwrite, i_id_memread, i_hold, i_flush,
`ifdef EX_HAZARD_FWD_CHECK_EN
    output o_err,
`endif
    output o_stall, o_fwd_sel, o_ex_valid
  );

endinterface

// File: rtl/ex_hazard_stage_reg.sv
// rtl/ex_hazard_stage_reg.sv - one shadow pipeline stage (valid, rd, regwrite, memread)
module ex_hazard_stage_reg #(
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_hold,
  input  logic              i_kill,
  input  logic              i_bubble,
  input  logic              i_valid,
  input  logic [REG_AW-1:0] i_rd,
  input  logic              i_regwrite,
  input  logic              i_memread,
  output logic              o_valid,
  output logic [REG_AW-1:0] o_rd,
  output logic              o_regwrite,
  output logic              o_memread
);

  logic              valid_q, valid_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              rw_q, rw_d;
  logic              mr_q, mr_d;

  // Hold keeps the entry (kill still drops it); otherwise load upstream or a zeroed bubble.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    mr_d    = mr_q;
    if (i_hold) begin
      if (i_kill) valid_d = 1'b0;
    end else if (i_bubble) begin
      valid_d = 1'b0;
      rd_d    = '0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
    end else begin
      valid_d = i_valid;
      rd_d    = i_rd;
      rw_d    = i_regwrite;
      mr_d    = i_memread;
    end
  end

  // Stage state register with synchronous clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_rd       = rd_q;
  assign o_regwrite = rw_q;
  assign o_memread  = mr_q;

endmodule

// File: rtl/ex_hazard_fwd_unit.sv
// rtl/ex_hazard_fwd_unit.sv - EX forwarding selects and load-use stall; EX_HAZARD_FWD_CHECK_EN adds sticky o_err
module ex_hazard_fwd_unit
  import ex_hazard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int REG_AW  = REG_AW_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  ex_hazard_fwd_unit_if.slave  bus
);

  localparam int SEL_W = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > MAX_DEPTH || NUM_SRC < 1 || NUM_SRC > MAX_NUM_SRC) begin : g_bad_param
    $error("ex_hazard_fwd_unit: DEPTH or NUM_SRC out of range");
  end

  logic              st_valid [DEPTH];
  logic [REG_AW-1:0] st_rd    [DEPTH];
  logic              st_rw    [DEPTH];
  logic              st_mr    [DEPTH];

  logic [NUM_SRC-1:0][REG_AW-1:0] rs_q, rs_d;
  logic                           stall_c;
  logic                           capture;
  logic [NUM_SRC*SEL_W-1:0]       fwd_sel_c;

  assign capture = bus.i_id_valid & ~stall_c & ~bus.i_flush;

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    if (s == 0) begin : g_ex
      ex_hazard_stage_reg #(.REG_AW(REG_AW)) u_stage (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_hold     (bus.i_hold),
        .i_kill     (bus.i_flush),
        .i_bubble   (!capture),
        .i_valid    (bus.i_id_valid),
        .i_rd       (bus.i_id_rd),
        .i_regwrite (bus.i_id_regwrite),
        .i_memread  (bus.i_id_memread),
        .o_valid    (st_valid[s]),
        .o_rd       (st_rd[s]),
        .o_regwrite (st_rw[s]),
        .o_memread  (st_mr[s])
      );
    end else begin : g_tail
      ex_hazard_stage_reg #(.REG_AW(REG_AW)) u_stage (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_hold     (bus.i_hold),
        .i_kill     (1'b0),
        .i_bubble   (1'b0),
        .i_valid    (st_valid[s-1]),
        .i_rd       (st_rd[s-1]),
        .i_regwrite (st_rw[s-1]),
        .i_memread  (st_mr[s-1]),
        .o_valid    (st_valid[s]),
        .o_rd       (st_rd[s]),
        .o_regwrite (st_rw[s]),
        .o_memread  (st_mr[s])
      );
    end
  end

  // EX operand registers follow stage 0: hold keeps, bubble zeroes, capture loads.
  always_comb begin
    rs_d = rs_q;
    if (!bus.i_hold) begin
      if (capture) rs_d = bus.i_id_rs;
      else         rs_d = '0;
    end
  end

  // Operand register update.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) rs_q <= '0;
    else          rs_q <= rs_d;
  end

  // Load in EX whose rd is read by ID forces one bubble; hold or flush suppress it.
  always_comb begin
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (bus.i_id_rs[j*REG_AW +: REG_AW] == st_rd[0]) hit = 1'b1;
    end
    stall_c = bus.i_id_valid & st_valid[0] & st_mr[0] & st_rw[0] & (|st_rd[0]) & hit
            & ~bus.i_flush & ~bus.i_hold;
  end

  // Youngest matching producer wins: scan oldest to youngest so the lowest stage overwrites.
  always_comb begin
    logic [SEL_W-1:0] sel;
    fwd_sel_c = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      sel = SEL_W'(FWD_REGFILE);
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (st_valid[k] && st_rw[k] && (|st_rd[k]) && (st_rd[k] == rs_q[j])) sel = SEL_W'(k);
      end
      if (st_valid[0]) fwd_sel_c[j*SEL_W +: SEL_W] = sel;
    end
  end

  assign bus.o_stall    = stall_c;
  assign bus.o_fwd_sel  = fwd_sel_c;
  assign bus.o_ex_valid = st_valid[0];

  // The oldest stage's memread flag has no consumer; it falls off the pipe.
  logic unused_oldest_mr;
  assign unused_oldest_mr = st_mr[DEPTH-1];

`ifdef EX_HAZARD_FWD_CHECK_EN
  logic err_q, err_d;
  logic bad_c;

  // A stage-1 load should never be a forwarding source, and a stall needs a valid EX entry.
  always_comb begin
    bad_c = stall_c & ~st_valid[0];
    for (int j = 0; j < NUM_SRC; j++) begin
      if (fwd_sel_c[j*SEL_W +: SEL_W] == SEL_W'(1) && st_mr[1]) bad_c = 1'b1;
    end
    err_d = err_q | bad_c;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign bus.o_err = err_q;

`ifndef SYNTHESIS
  // Simulation report of the same conditions.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && bad_c) $error("ex_hazard_fwd_unit: load forward from stage 1 or stall without EX entry");
  end
`endif
`endif

endmodule

// File: doc/ex_hazard_fwd_unit.md
Name: ex_hazard_fwd_unit

Overview:
- Parametrised forwarding and hazard unit for the EX stage.
- Keeps its own shadow pipeline of destination-register and control bits for DEPTH stages (EX, MEM, WB, ...).
- Per cycle it produces a forwarding select for each of NUM_SRC EX operands and a load-use stall request back to IF/ID.
- Sits beside the datapath; the operand muxes in EX consume o_fwd_sel.

Parameters:
- NUM_SRC, 2, number of source operands per instruction (1..4).
- DEPTH, 3, tracked stages after ID: stage 0 = EX, 1 = MEM, 2 = WB, ... (2..8).
- REG_AW, 5, register address width.
- SEL_W, $clog2(DEPTH), width of one forwarding select field (derived, not overridden).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_id_valid  in  1  ID holds a valid instruction to issue.
- i_id_rs  in  NUM_SRC*REG_AW  ID source registers, operand j at bits [j*REG_AW +: REG_AW].
- i_id_rd  in  REG_AW  ID destination register.
- i_id_regwrite  in  1  ID instruction writes rd.
- i_id_memread  in  1  ID instruction is a load.
- i_hold  in  1  global freeze (memory busy); shadow pipeline holds.
- i_flush  in  1  kill the instruction entering EX (branch taken).
- o_stall  out  1  load-use stall: keep PC and IF/ID, bubble EX.
- o_fwd_sel  out  NUM_SRC*SEL_W  per EX operand: 0 = register file, k = forward from stage k.
- o_ex_valid  out  1  EX-stage shadow entry is valid.

Behaviour:
- Shadow stage s holds: valid, rd, regwrite, memread. Stage 0 additionally holds rs[NUM_SRC].
- Reset (i_rst_n = 0 at a rising edge): all valid bits cleared, all fields zeroed.
- Reset outputs: o_stall = 0, o_fwd_sel = 0, o_ex_valid = 0.
- Per-edge update priority: reset > hold > normal.
  - hold: every stage keeps its value. i_flush is still honoured: stage 0 valid is cleared.
  - normal: stage s takes stage s-1 for s >= 1. Stage 0 takes the ID fields with valid = i_id_valid & ~o_stall & ~i_flush. When the ID instruction is not captured, stage 0 becomes a bubble (valid = 0).
  - The oldest stage's content drops out.
- o_stall (combinational):
  - Asserted when i_id_valid & stage0.valid & stage0.memread & stage0.regwrite & (stage0.rd != 0) & (stage0.rd == any i_id_rs[j]).
  - Forced to 0 when i_flush = 1 or i_hold = 1.
  - Exactly one bubble per load-use pair. Next cycle the load is in stage 1 and stage 0 is a bubble, so there is no repeat stall.
- o_fwd_sel[j] (combinational from registered state only):
  - Requires stage0.valid. Otherwise the field is 0.
  - Pick the smallest k in 1..DEPTH-1 with stage k valid & regwrite & rd != 0 & rd == stage0.rs[j]. The youngest producer wins; the field is k.
  - No match gives 0. x0 is never forwarded.
  - A stage-1 match whose producer has memread = 1 cannot occur by construction; the optional check flags it.
- Latency: an ID instruction captured at edge n is in EX during cycle n+1, with o_fwd_sel valid in that cycle.
- Stage-k entry for rd == 0 with regwrite = 1: ignored for forwarding and for stall.
- Simultaneous matches in several stages: lowest k only.
- Reset mid-stall: the stall is removed in the cycle after the reset edge, because the pipeline is empty.

Optional Feature:
- Macro: EX_HAZARD_FWD_CHECK_EN.
- Defined:
  - Adds an output o_err (1 bit), sticky, cleared only by reset.
  - o_err is set when a forward would select a stage-1 load producer.
  - o_err is also set when o_stall = 1 while stage0.valid = 0.
  - The same conditions are checked with simulation $error.
- Undefined: no o_err port, no extra logic.

Decomposition:
- Package ex_hazard_pkg: FWD_REGFILE = 0 constant, a stage-entry struct/field-width constants (REG_AW default), and max DEPTH/NUM_SRC limits.
- One natural sub-module: ex_hazard_stage_reg, a single shadow-stage register with hold/flush/bubble inputs, instantiated DEPTH times by generate.
- Select/priority logic stays in the top.

Test Plan:
- Reset is asserted for 2 cycles, then ID issues add x3 (rd = 3, rw = 1) and then sub rs = {3, 3}. In cycle 2, o_fwd_sel = {1, 1}. A third instruction with rs = {3, 0} in cycle 3 gives fields {2, 0}.
- Load-use:
  - Stimulus: lw x5, then add rs = {5, 7} in ID the next cycle.
  - Stall: o_stall = 1 for exactly 1 cycle, and stage0.valid = 0 in the following cycle.
  - Consumer in EX: o_fwd_sel[0] = 2 (WB) and o_fwd_sel[1] = 0.
- Double producer: instructions write x9 at stages 1 and 2, and the EX consumer reads x9. Required result is sel = 1.
- x0 case: producer writes rd = 0 with rw = 1, the consumer reads x0, and a load targets x0. Required result is sel = 0 and o_stall = 0.
- Hold and flush:
  - i_hold for 3 cycles: outputs are frozen.
  - i_flush together with hold: o_ex_valid = 0 next cycle, and the flushed instruction never forwards or stalls.
  - Flush during a load-use: o_stall = 0.
- Param sweep: NUM_SRC = 3 and DEPTH = 5 (SEL_W = 3). A producer 4 stages ahead gives sel = 4, and random streams match a reference model.
